// File: rtl/stat_reporter_pkg.sv
// Shared constants and types for the statistics report framer.
package stat_reporter_pkg;

  localparam logic [7:0] HDR_BYTE  = 8'hA5;
  localparam int         FRAME_LEN = 5;
  localparam logic [2:0] LAST_IDX  = 3'(FRAME_LEN - 1);
  localparam int         FLAG_OVF  = 0;
  localparam int         FLAG_DROP = 1;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic logic [7:0] flags_byte(input logic ovf, input logic drop);
    logic [7:0] f;
    f = '0;
    f[FLAG_OVF]  = ovf;
    f[FLAG_DROP] = drop;
    return f;
  endfunction

endpackage

// File: rtl/stat_reporter_window_timer.sv
// Free-running window counter 0..WINDOW-1; tick is high while the count sits at WINDOW-1.
module window_timer #(
  parameter int WINDOW = 256
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int CW = $clog2(WINDOW);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (count == CW'(WINDOW - 1)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = !reset && (count == CW'(WINDOW - 1));

endmodule

// File: rtl/stat_reporter.sv
// Snapshots upstream statistics once per window and emits a 5-byte report frame.
// Outputs are registered; a window end during an unfinished frame is counted as dropped.
module stat_reporter
  import stat_reporter_pkg::*;
#(
  parameter int WINDOW = 256
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] EvenParity,
  input  logic [7:0] GreyCode,
  input  logic       overflow,
  output logic       clear,
  output logic [7:0] RptData,
  output logic       RptValid,
  output logic       RptLast,
  input  logic       RptReady
);

  logic       tick;
  state_t     state;
  logic [2:0] idx;
  logic [7:0] seq;
  logic [7:0] seq_snap;
  logic [7:0] ep_snap;
  logic [7:0] gc_snap;
  logic       ovf_snap;
  logic       drop_snap;
  logic       dropped;
  logic       accept;
  logic       frame_done;
  logic       start;
  logic [7:0] next_byte;

  window_timer #(.WINDOW(WINDOW)) u_timer (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  assign accept     = RptValid && RptReady;
  assign frame_done = (state == SEND) && accept && (idx == LAST_IDX);
  // A window end may start a frame in the same cycle the previous one finishes.
  assign start      = tick && ((state == IDLE) || frame_done);

  always_comb begin
    next_byte = flags_byte(ovf_snap, drop_snap);
    case (idx)
      3'd0:    next_byte = seq_snap;
      3'd1:    next_byte = ep_snap;
      3'd2:    next_byte = gc_snap;
      default: next_byte = flags_byte(ovf_snap, drop_snap);
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      seq       <= '0;
      seq_snap  <= '0;
      ep_snap   <= '0;
      gc_snap   <= '0;
      ovf_snap  <= 1'b0;
      drop_snap <= 1'b0;
      dropped   <= 1'b0;
      clear     <= 1'b0;
      RptData   <= '0;
      RptValid  <= 1'b0;
      RptLast   <= 1'b0;
    end else begin
      clear <= tick;
      if (tick) begin
        seq <= seq + 8'd1;
      end

      if (tick && !start) begin
        dropped <= 1'b1;
      end else if (start) begin
        dropped <= 1'b0;
      end

      if (start) begin
        state     <= SEND;
        idx       <= '0;
        seq_snap  <= seq;
        ep_snap   <= EvenParity;
        gc_snap   <= GreyCode;
        ovf_snap  <= overflow;
        drop_snap <= dropped;
        RptData   <= HDR_BYTE;
        RptValid  <= 1'b1;
        RptLast   <= 1'b0;
      end else if (frame_done) begin
        state    <= IDLE;
        idx      <= '0;
        RptData  <= '0;
        RptValid <= 1'b0;
        RptLast  <= 1'b0;
      end else if ((state == SEND) && accept) begin
        idx     <= idx + 3'd1;
        RptData <= next_byte;
        RptLast <= (idx == LAST_IDX - 3'd1);
      end
    end
  end

endmodule

// File: tb/tb_stat_reporter.sv
// Scoreboard bench for stat_reporter with WINDOW=8; all comparisons live in the negedge monitor.
module tb_stat_reporter;

  localparam int W = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] EvenParity = 8'h00;
  logic [7:0] GreyCode = 8'h00;
  logic       overflow = 1'b0;
  logic       RptReady = 1'b0;
  logic       clear;
  logic [7:0] RptData;
  logic       RptValid;
  logic       RptLast;

  stat_reporter #(.WINDOW(W)) dut (
    .clock     (clock),
    .reset     (reset),
    .EvenParity(EvenParity),
    .GreyCode  (GreyCode),
    .overflow  (overflow),
    .clear     (clear),
    .RptData   (RptData),
    .RptValid  (RptValid),
    .RptLast   (RptLast),
    .RptReady  (RptReady)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] dat;
    logic       last;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_b;
  int    checks = 0;
  int    failures = 0;
  int    cyc = -1;
  int    clear_cnt = 0;
  int    cnt_exp = 0;
  logic  exp_clear = 1'b0;
  logic  vld_en = 1'b0;
  logic  exp_vld = 1'b0;
  logic  rst_chk = 1'b0;
  logic  cnt_chk = 1'b0;
  logic  empty_chk = 1'b0;
  logic  hold = 1'b0;
  logic [9:0] hold_val = '0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: the only process that compares.
  always @(negedge clock) begin
    if (RptValid && RptReady) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL beat_unexpected: got data=%02h last=%0b expected no beat", RptData, RptLast);
      end else begin
        mon_b = exp_q.pop_front();
        chk("beat_data", 16'(RptData), 16'(mon_b.dat));
        chk("beat_last", 16'(RptLast), 16'(mon_b.last));
      end
    end
    if (hold && !reset) begin
      chk("hold_stable", 16'({RptValid, RptData, RptLast}), 16'(hold_val));
    end
    hold     = RptValid && !RptReady && !reset;
    hold_val = {RptValid, RptData, RptLast};

    if (reset) clear_cnt = 0;
    else if (clear) clear_cnt++;

    chk("clear", 16'(clear), 16'(exp_clear));
    if (vld_en) chk("valid_timing", 16'(RptValid), 16'(exp_vld));
    if (rst_chk) begin
      chk("rst_valid", 16'(RptValid), 16'h0);
      chk("rst_last", 16'(RptLast), 16'h0);
      chk("rst_data", 16'(RptData), 16'h0);
      chk("rst_clear", 16'(clear), 16'h0);
    end
    if (cnt_chk) chk("clear_count", 16'(clear_cnt), 16'(cnt_exp));
    if (empty_chk) chk("queue_empty", 16'(exp_q.size()), 16'h0);
  end

  task automatic push_frame(input logic [7:0] seq, input logic [7:0] ep,
                            input logic [7:0] gc, input logic [7:0] flags);
    exp_q.push_back('{dat: 8'hA5, last: 1'b0});
    exp_q.push_back('{dat: seq,   last: 1'b0});
    exp_q.push_back('{dat: ep,    last: 1'b0});
    exp_q.push_back('{dat: gc,    last: 1'b0});
    exp_q.push_back('{dat: flags, last: 1'b1});
  endtask

  task automatic tick_cycle();
    @(posedge clock);
    #1;
    if (cyc >= 0) cyc++;
    rst_chk   = 1'b0;
    vld_en    = 1'b0;
    cnt_chk   = 1'b0;
    empty_chk = 1'b0;
    exp_clear = (cyc > 0) && (cyc % W == 0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    cyc       = -1;
    exp_clear = 1'b0;
    tick_cycle();
    rst_chk = 1'b1;
    tick_cycle();
    reset     = 1'b0;
    cyc       = 0;
    exp_clear = 1'b0;
  endtask

  // mode 0: ready high; 1: ready toggles; 2: ready low until cycle 20; 3: overflow toggling.
  task automatic run(input int last_c, input int mode);
    while (cyc < last_c) begin
      tick_cycle();
      case (mode)
        1: RptReady = (cyc % 2 == 0);
        2: begin
          RptReady = (cyc >= 20);
          if (cyc == 10) begin
            EvenParity = 8'h77;
            GreyCode   = 8'h88;
          end
          if (cyc == 25) begin
            cnt_chk = 1'b1;
            cnt_exp = 3;
            vld_en  = 1'b1;
            exp_vld = 1'b0;
          end
          if (cyc == 32) begin
            vld_en  = 1'b1;
            exp_vld = 1'b1;
          end
        end
        3: overflow = (cyc <= 7) ? 1'b1 : (cyc % 2 == 1);
        default: RptReady = 1'b1;
      endcase
      if (mode == 0 || mode == 3) begin
        if (cyc == 7)  begin vld_en = 1'b1; exp_vld = 1'b0; end
        if (cyc == 8)  begin vld_en = 1'b1; exp_vld = 1'b1; end
        if (cyc == 13) begin vld_en = 1'b1; exp_vld = 1'b0; end
      end
    end
    empty_chk = 1'b1;
  endtask

  initial begin
    do_reset();
    EvenParity = 8'h12; GreyCode = 8'h03; overflow = 1'b0; RptReady = 1'b1;
    push_frame(8'h00, 8'h12, 8'h03, 8'h00);
    run(14, 0);

    do_reset();
    EvenParity = 8'h5A; GreyCode = 8'hC3; RptReady = 1'b1;
    push_frame(8'h00, 8'h5A, 8'hC3, 8'h00);
    run(18, 1);

    do_reset();
    EvenParity = 8'h12; GreyCode = 8'h03; RptReady = 1'b0;
    push_frame(8'h00, 8'h12, 8'h03, 8'h00);
    push_frame(8'h03, 8'h77, 8'h88, 8'h02);
    run(38, 2);

    do_reset();
    EvenParity = 8'h9C; GreyCode = 8'h41; overflow = 1'b1; RptReady = 1'b1;
    push_frame(8'h00, 8'h9C, 8'h41, 8'h01);
    run(14, 3);

    do_reset();
    EvenParity = 8'h12; GreyCode = 8'h03; overflow = 1'b0; RptReady = 1'b1;
    for (int k = 0; k < 257; k++) push_frame(8'(k), 8'h12, 8'h03, 8'h00);
    run(8 * 256 + 14, 0);

    // Reset lands while the third byte is on the bus; the frame must not resume.
    do_reset();
    exp_q.push_back('{dat: 8'hA5, last: 1'b0});
    exp_q.push_back('{dat: 8'h00, last: 1'b0});
    exp_q.push_back('{dat: 8'h12, last: 1'b0});
    run(10, 0);
    do_reset();
    push_frame(8'h00, 8'h12, 8'h03, 8'h00);
    run(14, 0);

    do_reset();
    tick_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stat_reporter.md
STAT_REPORTER -- requirements
Module: stat_reporter

Interface
REQ-001 SHALL have parameter: WINDOW, 256, sampling window length in clock cycles (legal 8..65535).
REQ-002 SHALL have port: clock  input  1  single clock, all logic on posedge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: EvenParity  input  8  registered even-parity count from upstream statistics stage.
REQ-005 SHALL have port: GreyCode  input  8  registered alternating-pattern count from upstream statistics stage.
REQ-006 SHALL have port: overflow  input  1  sticky counter-overflow flag from upstream statistics stage.
REQ-007 SHALL have port: clear  output  1  registered one-cycle pulse to upstream statistics stage, zeroing its counters.
REQ-008 SHALL have port: RptData  output  8  report byte.
REQ-009 SHALL have port: RptValid  output  1  RptData valid.
REQ-010 SHALL have port: RptLast  output  1  marks final byte of a frame, qualified by RptValid.
REQ-011 SHALL have port: RptReady  input  1  downstream accepts byte when RptValid and RptReady are both high at posedge.

Function
REQ-012 Window counter SHALL count 0..WINDOW-1 and wrap to 0 every cycle reset is low.
REQ-013 In the cycle the counter equals WINDOW-1: snapshot EvenParity, GreyCode, overflow; drive clear=1 on the next cycle only (clear is high exactly 1 cycle per window).
REQ-014 Upstream data arriving during the clear cycle is discarded by upstream; no compensation here.
REQ-015 Sequence number: 8-bit, incremented once per window end whether or not the frame is sent; 255 wraps to 0.
REQ-016 Frame: 5 bytes in order 0xA5, SEQ, EvenParity snapshot, GreyCode snapshot, FLAGS; RptLast=1 on FLAGS byte only.
REQ-017 FLAGS: bit0 = snapshot overflow, bit1 = dropped (at least one earlier window skipped since last sent frame), bits7:2 = 0.
REQ-018 FSM states: IDLE (no frame pending), SEND (bytes 0..4, byte index 3 bits).
REQ-019 IDLE->SEND in the cycle after a window end; RptValid rises in that same cycle with header byte.
REQ-020 In SEND, byte index SHALL advance only on RptValid&RptReady; RptData/RptValid/RptLast SHALL stay stable while RptReady is low.
REQ-021 SEND->IDLE on acceptance of FLAGS byte; RptValid low the following cycle unless a new window end coincides (then IDLE is skipped, next frame begins immediately).
REQ-022 Window end while in SEND (frame not completed): new snapshot discarded, sticky dropped bit set, clear still pulsed, sequence still increments.
REQ-023 Dropped bit SHALL be loaded into FLAGS when a frame starts and cleared at that point; set at same cycle wins over clearing.
REQ-024 No combinational path from RptReady to RptValid or RptData.

Reset
REQ-025 On reset: window counter=0, SEQ=0, FSM=IDLE, dropped=0, snapshot regs=0, clear=0, RptValid=0, RptLast=0, RptData=0.
REQ-026 Reset asserted mid-frame SHALL abort the frame; no partial frame resumes after reset.
REQ-027 clear SHALL NOT be asserted by reset (upstream has its own reset).

Structure
REQ-028 Shared package SHALL hold: header constant 0xA5, frame length 5, FLAGS bit positions, FSM state encoding.
REQ-029 Window counter SHALL be a sub-module window_timer (parameter WINDOW, output one-cycle tick); rest is flat.

Verification
REQ-030 WINDOW=8, EvenParity=0x12, GreyCode=0x03, overflow=0, RptReady=1 -> clear high in cycle 8 after reset release; bytes A5,00,12,03,00 on 5 consecutive cycles, RptLast on 5th.
REQ-031 RptReady toggling 1010... -> same 5-byte frame, each byte held stable while RptReady low, no byte lost or duplicated.
REQ-032 RptReady=0 for 20 cycles with WINDOW=8 -> two window ends dropped, clear pulsed 3 times total; released frame carries SEQ=00, next sent frame SEQ=03 with FLAGS=0x02.
REQ-033 overflow=1 at snapshot -> FLAGS=0x01; overflow toggled after snapshot does not change frame.
REQ-034 Run 256 windows with RptReady=1 -> SEQ goes FF then 00.
REQ-035 Reset asserted on 3rd byte of frame -> RptValid=0 next cycle, SEQ restarts at 00, window count restarts.
